// File: rtl/rom_arbiter.sv
// Shares one combinational-read instruction ROM between the fetch port (F) and the data-side literal port (D).
// At most one grant per cycle: D has priority, with a streak limit so a waiting fetch cannot starve. Responses are registered.
module rom_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_f_req_valid,
  input  logic [31:0] i_f_req_addr,
  output logic        o_f_req_ready,
  output logic        o_f_resp_valid,
  output logic [31:0] o_f_resp_data,
  output logic        o_f_resp_error,
  input  logic        i_d_req_valid,
  input  logic [31:0] i_d_req_addr,
  output logic        o_d_req_ready,
  output logic        o_d_resp_valid,
  output logic [31:0] o_d_resp_data,
  output logic        o_d_resp_error,
  output logic        o_rom_chip_enable,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_instruction
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  logic [3:0]  r_streak;
  logic        r_f_resp_valid;
  logic        r_f_resp_error;
  logic [31:0] r_f_resp_data;
  logic        r_d_resp_valid;
  logic        r_d_resp_error;
  logic [31:0] r_d_resp_data;

  logic        w_f_eligible;
  logic        w_d_eligible;
  logic        w_grant_f;
  logic        w_grant_d;
  logic        w_granted;
  logic [31:0] w_grant_addr;
  logic        w_misaligned;
  logic [31:0] w_word;

  assign w_f_eligible = i_f_req_valid & ~i_flush;
  assign w_d_eligible = i_d_req_valid;

  // Nothing is granted while reset is held.
  always_comb begin
    w_grant_f = 1'b0;
    w_grant_d = 1'b0;
    if (!i_reset) begin
      if (w_d_eligible && w_f_eligible && (r_streak == BURST_MAX)) begin
        w_grant_f = 1'b1;
      end else if (w_d_eligible) begin
        w_grant_d = 1'b1;
      end else if (w_f_eligible) begin
        w_grant_f = 1'b1;
      end
    end
  end

  assign w_granted         = w_grant_f | w_grant_d;
  assign w_grant_addr      = w_grant_f ? i_f_req_addr : i_d_req_addr;
  assign w_misaligned      = w_granted & (w_grant_addr[1:0] != 2'b00);
  assign w_word            = w_misaligned ? 32'h0 : i_rom_instruction;

  assign o_f_req_ready     = w_grant_f;
  assign o_d_req_ready     = w_grant_d;
  assign o_rom_chip_enable = w_granted & ~w_misaligned;
  assign o_rom_addr        = o_rom_chip_enable ? w_grant_addr : 32'h0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_f_resp_valid <= 1'b0;
      r_f_resp_error <= 1'b0;
      r_f_resp_data  <= 32'h0;
      r_d_resp_valid <= 1'b0;
      r_d_resp_error <= 1'b0;
      r_d_resp_data  <= 32'h0;
    end else begin
      r_f_resp_valid <= w_grant_f;
      r_f_resp_error <= w_grant_f & w_misaligned;
      r_d_resp_valid <= w_grant_d;
      r_d_resp_error <= w_grant_d & w_misaligned;
      if (w_grant_f) r_f_resp_data <= w_word;
      if (w_grant_d) r_d_resp_data <= w_word;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || w_grant_f || !i_f_req_valid) begin
      r_streak <= 4'd0;
    end else if (w_grant_d && (r_streak != BURST_MAX)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // A flush kills the fetch response that is currently being presented; reset drops any pending pulse.
  assign o_f_resp_valid = r_f_resp_valid & ~i_flush & ~i_reset;
  assign o_f_resp_error = r_f_resp_error & ~i_flush & ~i_reset;
  assign o_f_resp_data  = r_f_resp_data;
  assign o_d_resp_valid = r_d_resp_valid & ~i_reset;
  assign o_d_resp_error = r_d_resp_error & ~i_reset;
  assign o_d_resp_data  = r_d_resp_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a cycle-level model checks every output at each falling edge,
// and a directed sequence pins key cycles with literal expectations.
module tb_rom_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        f_valid, d_valid;
  logic [31:0] f_addr, d_addr;
  logic        f_ready, f_rv, f_re, d_ready, d_rv, d_re;
  logic [31:0] f_rd, d_rd;
  logic        rom_en;
  logic [31:0] rom_addr, rom_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hCAFE0000 | (a >> 2);
  endfunction

  assign rom_data = rom_en ? rom_word(rom_addr) : 32'h0;

  rom_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
    .i_clock(clk), .i_reset(reset), .i_flush(flush),
    .i_f_req_valid(f_valid), .i_f_req_addr(f_addr), .o_f_req_ready(f_ready),
    .o_f_resp_valid(f_rv), .o_f_resp_data(f_rd), .o_f_resp_error(f_re),
    .i_d_req_valid(d_valid), .i_d_req_addr(d_addr), .o_d_req_ready(d_ready),
    .o_d_resp_valid(d_rv), .o_d_resp_data(d_rd), .o_d_resp_error(d_re),
    .o_rom_chip_enable(rom_en), .o_rom_addr(rom_addr), .i_rom_instruction(rom_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending responses and the consecutive-data count seen by a waiting fetch.
  bit          m_known = 0;
  bit          m_fv, m_fe, m_dv, m_de;
  logic [31:0] m_fd, m_dd;
  int          m_streak = 0;

  always @(negedge clk) begin
    bit fe, de, gf, gd, mis, en;
    logic [31:0] ga;
    fe = f_valid && !flush;
    de = d_valid;
    gf = 0;
    gd = 0;
    if (!reset) begin
      if (de && fe && m_streak == MAXB) gf = 1;
      else if (de) gd = 1;
      else if (fe) gf = 1;
    end
    ga  = gf ? f_addr : d_addr;
    mis = (gf || gd) && (ga % 4 != 0);
    en  = (gf || gd) && !mis;
    chk("m_f_ready", 32'(f_ready), 32'(gf));
    chk("m_d_ready", 32'(d_ready), 32'(gd));
    chk("m_rom_en", 32'(rom_en), 32'(en));
    chk("m_rom_addr", rom_addr, en ? ga : 32'h0);
    if (m_known) begin
      chk("m_f_resp_valid", 32'(f_rv), 32'(m_fv && !reset && !flush));
      chk("m_f_resp_error", 32'(f_re), 32'(m_fe && !reset && !flush));
      chk("m_f_resp_data", f_rd, m_fd);
      chk("m_d_resp_valid", 32'(d_rv), 32'(m_dv && !reset));
      chk("m_d_resp_error", 32'(d_re), 32'(m_de && !reset));
      chk("m_d_resp_data", d_rd, m_dd);
    end
    if (reset) begin
      m_known = 1;
      m_fv = 0; m_fe = 0; m_dv = 0; m_de = 0;
      m_fd = 0; m_dd = 0;
      m_streak = 0;
    end else begin
      m_fv = gf; m_fe = gf && mis;
      m_dv = gd; m_de = gd && mis;
      if (gf) m_fd = mis ? 32'h0 : rom_word(ga);
      if (gd) m_dd = mis ? 32'h0 : rom_word(ga);
      if (!f_valid || gf) m_streak = 0;
      else if (gd && m_streak < MAXB) m_streak = m_streak + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fv, input logic [31:0] fa, input bit dv, input logic [31:0] da);
    f_valid = fv; f_addr = fa; d_valid = dv; d_addr = da;
  endtask

  initial begin
    logic [9:0] pat;
    pat = 10'b0111101111;
    reset = 1; flush = 0;
    drive(1, 32'h0, 1, 32'h8);
    @(negedge clk);
    chk("rst1_f_ready", 32'(f_ready), 0);
    chk("rst1_d_ready", 32'(d_ready), 0);
    chk("rst1_rom_en", 32'(rom_en), 0);
    next_cycle();
    @(negedge clk);
    chk("rst2_ready", 32'({f_ready, d_ready}), 0);
    chk("rst2_resp_valid", 32'({f_rv, d_rv, f_re, d_re}), 0);
    chk("rst2_f_data", f_rd, 0);
    chk("rst2_d_data", d_rd, 0);

    next_cycle(); reset = 0;
    @(negedge clk);
    chk("post_rst_d_ready", 32'(d_ready), 1);
    chk("post_rst_rom_addr", rom_addr, 32'h8);

    next_cycle(); drive(1, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("fetch0_ready", 32'(f_ready), 1);
    chk("d_resp_word2", d_rd, 32'hCAFE0002);
    next_cycle(); drive(1, 32'h4, 0, 32'h0);
    @(negedge clk);
    chk("fetch_resp0", f_rd, 32'hCAFE0000);
    chk("fetch_resp0_err", 32'(f_re), 0);
    next_cycle(); drive(1, 32'h8, 0, 32'h0);
    @(negedge clk);
    chk("fetch_resp1", f_rd, 32'hCAFE0001);

    for (int i = 0; i < 10; i++) begin
      next_cycle(); drive(1, 32'h100, 1, 32'h200);
      @(negedge clk);
      chk($sformatf("burst_d_ready_%0d", i), 32'(d_ready), 32'(pat[i]));
      chk($sformatf("burst_f_ready_%0d", i), 32'(f_ready), 32'(!pat[i]));
      if (i == 0) chk("fetch_resp2", f_rd, 32'hCAFE0002);
      if (i == 5) chk("burst_f_resp_valid", 32'(f_rv), 1);
    end

    next_cycle(); drive(1, 32'hC, 0, 32'h0);
    @(negedge clk);
    chk("pre_flush_f_ready", 32'(f_ready), 1);
    next_cycle(); drive(1, 32'h10, 1, 32'h14); flush = 1;
    @(negedge clk);
    chk("flush_f_ready", 32'(f_ready), 0);
    chk("flush_d_ready", 32'(d_ready), 1);
    chk("flush_kill_f_resp", 32'(f_rv), 0);
    next_cycle(); drive(0, 32'h0, 0, 32'h0); flush = 0;
    @(negedge clk);
    chk("flush_d_resp_valid", 32'(d_rv), 1);
    chk("flush_d_resp_data", d_rd, 32'hCAFE0005);
    chk("flush_f_resp_valid", 32'(f_rv), 0);

    next_cycle(); drive(0, 32'h0, 1, 32'h6);
    @(negedge clk);
    chk("mis_d_ready", 32'(d_ready), 1);
    chk("mis_rom_en", 32'(rom_en), 0);
    next_cycle(); drive(0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("mis_d_resp_valid", 32'(d_rv), 1);
    chk("mis_d_resp_error", 32'(d_re), 1);
    chk("mis_d_resp_data", d_rd, 32'h0);

    next_cycle(); drive(1, 32'h30, 1, 32'h20);
    @(negedge clk);
    chk("pre_rst_d_ready", 32'(d_ready), 1);
    next_cycle(); reset = 1;
    @(negedge clk);
    chk("rst_drop_d_resp", 32'(d_rv), 0);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); reset = 0;
      @(negedge clk);
      chk($sformatf("rst_streak_d_ready_%0d", i), 32'(d_ready), 32'(pat[i]));
    end

    next_cycle(); drive(1, 32'h32, 0, 32'h0);
    @(negedge clk);
    chk("mis_f_rom_en", 32'(rom_en), 0);
    next_cycle(); drive(0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("mis_f_resp_error", 32'(f_re), 1);
    chk("mis_f_resp_data", f_rd, 32'h0);

    next_cycle();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
